// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: issues one request at a time, presents the fetched word
// to decode, and handles branch/jump redirects, including ones that arrive mid-request.
module pc_fetch_sequencer (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchPC,
    input  logic [15:0] BranchImm,
    input  logic        JumpValid,
    input  logic [31:0] JumpTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus4
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_VALID = 2'd1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    logic        redirect;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] redirect_tgt;

    always_comb begin
        branch_tgt   = BranchPC + 32'd4 + {{14{BranchImm[15]}}, BranchImm, 2'b00};
        jump_tgt     = {JumpTarget[31:2], 2'b00};
        redirect     = JumpValid | BranchTaken;
        redirect_tgt = JumpValid ? jump_tgt : branch_tgt;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        req_d      = req_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_plus4_d = pc_plus4_q;

        case (state_q)
            ST_FETCH: begin
                if (!req_q) begin
                    // Only reachable right after reset: no request is out, so any ack is stale.
                    if (redirect) begin
                        pc_d = redirect_tgt;
                    end
                    req_d = 1'b1;
                end else if (IMemAck) begin
                    if (redirect || pend_q) begin
                        pc_d   = redirect ? redirect_tgt : pend_tgt_q;
                        pend_d = 1'b0;
                        req_d  = 1'b1;
                    end else begin
                        instr_d    = IMemData;
                        instr_pc_d = pc_q;
                        pc_plus4_d = pc_q + 32'd4;
                        pc_d       = pc_q + 32'd4;
                        valid_d    = 1'b1;
                        req_d      = 1'b0;
                        state_d    = ST_VALID;
                    end
                end else if (redirect) begin
                    // Address must stay put until the ack, so park the target.
                    pend_d     = 1'b1;
                    pend_tgt_d = redirect_tgt;
                end
            end
            ST_VALID: begin
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end else if (!Stall) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                valid_d = 1'b0;
                req_d   = 1'b0;
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= 32'h0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            pc_plus4_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    assign IMemReq    = req_q;
    assign IMemAddr   = pc_q;
    assign InstrValid = valid_q;
    assign Instr      = instr_q;
    assign InstrPC    = instr_pc_q;
    assign PCPlus4    = pc_plus4_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: fetch order, stall hold, redirects, wrap and reset.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = 32'h0;
    logic [15:0] branch_imm = 16'h0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer dut (
        .Clk(clk), .Rst_n(rst_n), .Stall(stall),
        .BranchTaken(branch_taken), .BranchPC(branch_pc), .BranchImm(branch_imm),
        .JumpValid(jump_valid), .JumpTarget(jump_target),
        .IMemReq(imem_req), .IMemAddr(imem_addr), .IMemAck(imem_ack), .IMemData(imem_data),
        .InstrValid(instr_valid), .Instr(instr), .InstrPC(instr_pc), .PCPlus4(pc_plus4)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0BAD0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if ({instr_valid, instr, instr_pc, pc_plus4} !== 97'h0) begin errors++;
            $display("FAIL rst_outs got v=%b i=%h pc=%h p4=%h exp all 0", instr_valid, instr, instr_pc, pc_plus4); end
        step();
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req_held got %b exp 0", imem_req); end
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
            $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_ack_valid got %b exp 0", instr_valid); end
        imem_ack = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(i) * 32'd4;
            checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin errors++;
                $display("FAIL seq_req%0d got req=%b addr=%h v=%b exp req=1 addr=%h v=0", i, imem_req, imem_addr, instr_valid, exp_pc); end
            imem_ack  = 1'b1;
            imem_data = 32'h1000 + 32'(i);
            step();
            imem_ack  = 1'b0;
            checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++;
                $display("FAIL seq_valid%0d got v=%b req=%b exp v=1 req=0", i, instr_valid, imem_req); end
            checks++; if (instr !== 32'h1000 + 32'(i) || instr_pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin errors++;
                $display("FAIL seq_data%0d got i=%h pc=%h p4=%h exp i=%h pc=%h p4=%h", i, instr, instr_pc, pc_plus4,
                         32'h1000 + 32'(i), exp_pc, exp_pc + 32'd4); end
            step();
        end
    endtask

    task automatic test_stall();
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL stall_addr got %h exp c", imem_addr); end
        imem_ack  = 1'b1;
        imem_data = 32'h8C010004;
        step();
        imem_ack = 1'b0;
        stall    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h8C010004 || instr_pc !== 32'hC || imem_req !== 1'b0) begin errors++;
                $display("FAIL stall_hold%0d got v=%b i=%h pc=%h req=%b exp v=1 i=8c010004 pc=c req=0", i, instr_valid, instr, instr_pc, imem_req); end
        end
        stall = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL stall_release got req=%b addr=%h v=%b exp req=1 addr=10 v=0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_branch_pending();
        branch_taken = 1'b1;
        branch_pc    = 32'h10;
        branch_imm   = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++;
            $display("FAIL br_hold_addr got req=%b addr=%h exp req=1 addr=10", imem_req, imem_addr); end
        step();
        step();
        imem_ack  = 1'b1;
        imem_data = 32'hDEADBEEF;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++;
            $display("FAIL br_redirect got v=%b req=%b addr=%h exp v=0 req=1 addr=c", instr_valid, imem_req, imem_addr); end
        imem_ack  = 1'b1;
        imem_data = 32'h2000_000C;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h2000_000C || instr_pc !== 32'hC) begin errors++;
            $display("FAIL br_refetch got v=%b i=%h pc=%h exp v=1 i=2000000c pc=c", instr_valid, instr, instr_pc); end
        step();
    endtask

    task automatic test_redirect_overwrite();
        jump_valid  = 1'b1;
        jump_target = 32'h100;
        step();
        jump_target = 32'h200;
        step();
        jump_valid = 1'b0;
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL ovr_hold got %h exp 10", imem_addr); end
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (imem_addr !== 32'h200 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL ovr_target got addr=%h v=%b exp addr=200 v=0", imem_addr, instr_valid); end
        branch_taken = 1'b1;
        branch_pc    = 32'h40;
        branch_imm   = 16'h0001;
        step();
        branch_taken = 1'b0;
        jump_valid   = 1'b1;
        jump_target  = 32'h300;
        imem_ack     = 1'b1;
        step();
        jump_valid = 1'b0;
        imem_ack   = 1'b0;
        checks++; if (imem_addr !== 32'h300 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin errors++;
            $display("FAIL same_cycle_prio got addr=%h v=%b req=%b exp addr=300 v=0 req=1", imem_addr, instr_valid, imem_req); end
    endtask

    task automatic test_jump_in_valid();
        imem_ack  = 1'b1;
        imem_data = 32'h3000_0300;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300) begin errors++;
            $display("FAIL jv_valid got v=%b pc=%h exp v=1 pc=300", instr_valid, instr_pc); end
        stall        = 1'b1;
        jump_valid   = 1'b1;
        jump_target  = 32'h00400023;
        branch_taken = 1'b1;
        branch_pc    = 32'h10;
        branch_imm   = 16'h0;
        step();
        stall        = 1'b0;
        jump_valid   = 1'b0;
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00400020) begin errors++;
            $display("FAIL jv_redirect got v=%b req=%b addr=%h exp v=0 req=1 addr=00400020", instr_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        jump_valid  = 1'b1;
        jump_target = 32'hFFFFFFFC;
        imem_ack    = 1'b1;
        step();
        jump_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFFFFFC || instr_valid !== 1'b0) begin errors++;
            $display("FAIL wrap_jump got addr=%h v=%b exp addr=fffffffc v=0", imem_addr, instr_valid); end
        imem_data = 32'h4000_0004;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFFFFFC || pc_plus4 !== 32'h0) begin errors++;
            $display("FAIL wrap_valid got v=%b pc=%h p4=%h exp v=1 pc=fffffffc p4=0", instr_valid, instr_pc, pc_plus4); end
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++;
            $display("FAIL wrap_next got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_request();
        imem_ack  = 1'b1;
        imem_data = 32'h5000_0000;
        step();
        imem_ack = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++;
            $display("FAIL mid_pre got req=%b addr=%h exp req=1 addr=4", imem_req, imem_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
                      instr !== 32'h0 || instr_pc !== 32'h0 || pc_plus4 !== 32'h0) begin errors++;
            $display("FAIL mid_async got req=%b addr=%h v=%b i=%h pc=%h p4=%h exp all 0", imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4); end
        step();
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'h6666_6666;
        step();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL mid_restart got req=%b addr=%h v=%b exp req=1 addr=0 v=0", imem_req, imem_addr, instr_valid); end
        imem_ack  = 1'b1;
        imem_data = 32'h7000_0000;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h7000_0000 || instr_pc !== 32'h0 || pc_plus4 !== 32'h4) begin errors++;
            $display("FAIL mid_first_fetch got v=%b i=%h pc=%h p4=%h exp v=1 i=70000000 pc=0 p4=4", instr_valid, instr, instr_pc, pc_plus4); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_pending();
        test_redirect_overwrite();
        test_jump_in_valid();
        test_wrap();
        test_reset_mid_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
